// File: rtl/div_share_arbiter_if.sv
// Bus bundle for div_share_arbiter: requester request/response lanes plus the
// shared divider sink/source handshakes. The arbiter uses the slave modport.
interface div_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*17-1:0] req_numer;
  logic [NUM_REQ*16-1:0] req_denom;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [16:0]           rsp_data;
  logic                  rsp_div0;
  logic                  div_snk_valid;
  logic [16:0]           div_snk_numer;
  logic [15:0]           div_snk_denom;
  logic                  div_snk_ready;
  logic                  div_src_valid;
  logic [16:0]           div_src_data;
  logic                  div_src_ready;

  modport slave (
    input  req_valid, req_numer, req_denom, rsp_ready,
    input  div_snk_ready, div_src_valid, div_src_data,
    output req_ready, rsp_valid, rsp_data, rsp_div0,
    output div_snk_valid, div_snk_numer, div_snk_denom, div_src_ready
  );

  modport master (
    output req_valid, req_numer, req_denom, rsp_ready,
    output div_snk_ready, div_src_valid, div_src_data,
    input  req_ready, rsp_valid, rsp_data, rsp_div0,
    input  div_snk_valid, div_snk_numer, div_snk_denom, div_src_ready
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one pipelined divider among NUM_REQ requesters, with an
// in-order tag FIFO routing quotients back. Optional macro: DIV_SHARE_ZERO_GUARD_EN.
module div_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  div_share_arbiter_if.slave bus
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned PTRW = $clog2(TAG_DEPTH);
  localparam int unsigned CNTW = PTRW + 1;
  localparam int unsigned NW   = 17;
  localparam int unsigned DW   = 16;

  logic [IDW-1:0]  last;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand;
  logic            grant_found;
  logic [NW-1:0]   sel_numer;
  logic [DW-1:0]   sel_denom;
  logic [NW-1:0]   snk_numer;
  logic [DW-1:0]   snk_denom;
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;
  logic [IDW-1:0]  tag_id [TAG_DEPTH];
  logic [IDW-1:0]  head_id;
  logic            any_req;
  logic            tag_full;
  logic            tag_empty;
  logic            issue;
  logic            pop;

  // Scan upward from last+1 with wrap; first asserted request wins.
  always_comb begin
    grant_idx   = last;
    grant_found = 1'b0;
    cand        = '0;
    sel_numer   = '0;
    sel_denom   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(last) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_numer = bus.req_numer[i*NW +: NW];
        sel_denom = bus.req_denom[i*DW +: DW];
      end
    end
  end

`ifdef DIV_SHARE_ZERO_GUARD_EN
  logic tag_div0 [TAG_DEPTH];
  logic denom_zero;
  logic head_div0;

  // Zero denominators become saturating max/1 and are flagged with the tag.
  always_comb begin
    denom_zero = (sel_denom == '0);
    snk_numer  = denom_zero ? NW'(17'h1FFFF) : sel_numer;
    snk_denom  = denom_zero ? DW'(1) : sel_denom;
  end

  always_ff @(posedge clk) begin
    if (issue) tag_div0[wr_ptr] <= denom_zero;
  end

  assign head_div0 = tag_div0[rd_ptr];
`else
  always_comb begin
    snk_numer = sel_numer;
    snk_denom = sel_denom;
  end
`endif

  assign any_req   = |bus.req_valid;
  assign tag_full  = (count == CNTW'(TAG_DEPTH));
  assign tag_empty = (count == '0);
  assign issue     = any_req & bus.div_snk_ready & ~tag_full;
  assign head_id   = tag_id[rd_ptr];
  assign pop       = bus.div_src_valid & bus.div_src_ready;

  // Handshake outputs are forced low while reset is held.
  always_comb begin
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.div_snk_valid = 1'b0;
    bus.div_src_ready = 1'b0;
    bus.rsp_div0      = 1'b0;
    bus.rsp_data      = bus.div_src_data;
    bus.div_snk_numer = snk_numer;
    bus.div_snk_denom = snk_denom;
    if (rst) begin
      bus.div_snk_valid = any_req & ~tag_full;
      if (issue) bus.req_ready = NUM_REQ'(1) << grant_idx;
      if (!tag_empty) begin
        bus.div_src_ready = bus.rsp_ready[head_id];
        if (bus.div_src_valid) begin
          bus.rsp_valid = NUM_REQ'(1) << head_id;
`ifdef DIV_SHARE_ZERO_GUARD_EN
          bus.rsp_div0  = head_div0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= IDW'(NUM_REQ - 1);
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + PTRW'(1);
        last   <= grant_idx;
      end
      if (pop) rd_ptr <= rd_ptr + PTRW'(1);
      count <= count + CNTW'(issue) - CNTW'(pop);
    end
  end

  // Tag payload needs no reset; occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (issue) tag_id[wr_ptr] <= grant_idx;
  end

  no_orphan_result: assert property (@(posedge clk) disable iff (!rst)
    !(bus.div_src_valid && tag_empty))
    else $error("div_share_arbiter: divider result arrived with empty tag FIFO");

endmodule
